// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and widths for the PUF challenge sequencer.
package puf_pkg;
  localparam int CHAL_W = 8;
  localparam int RESP_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    STEP   = 3'd4,
    EMIT   = 3'd5,
    FINISH = 3'd6
  } state_t;
endpackage

// File: rtl/puf_challenge_sequencer.sv
// Walks an external up_counter through NUM_CHAL challenges, lets the PUF settle on each,
// and packs eight response bits per word onto a valid/ready output.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_CHAL      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  output logic              cnt_reset,
  output logic              cnt_enable,
  output logic [CHAL_W-1:0] cnt_start,
  input  logic [CHAL_W-1:0] challenge,
  input  logic              puf_resp,
  output logic [RESP_W-1:0] resp_data,
  output logic [CHAL_W-1:0] resp_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [8:0] LAST_CHAL   = 9'(NUM_CHAL);

  state_t     state;
  logic [7:0] timer;
  logic [2:0] bit_idx;
  logic [8:0] chal_cnt;   // 9 bits so a 256-challenge run can reach its terminal count

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      chal_cnt  <= '0;
      cnt_start <= '0;
      resp_data <= '0;
      resp_tag  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt_start <= seed;
          chal_cnt  <= '0;
          bit_idx   <= '0;
          state     <= LOAD;
        end
        LOAD: begin
          timer <= SETTLE_LOAD;
          state <= SETTLE;
        end
        SETTLE: begin
          if (timer == 8'd0) state <= SAMPLE;
          else               timer <= timer - 8'd1;
        end
        SAMPLE: begin
          resp_data[bit_idx] <= puf_resp;
          if (bit_idx == 3'd0) resp_tag <= challenge;
          chal_cnt <= chal_cnt + 9'd1;
          bit_idx  <= bit_idx + 3'd1;
          state    <= (bit_idx == 3'd7) ? EMIT : STEP;
        end
        STEP: begin
          timer <= SETTLE_LOAD;
          state <= SETTLE;
        end
        // word is frozen here; the counter only moves again after the handshake
        EMIT: if (resp_ready) state <= (chal_cnt == LAST_CHAL) ? FINISH : STEP;
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cnt_reset  = (state == LOAD);
  assign cnt_enable = (state == STEP);
  assign resp_valid = (state == EMIT);
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: cycles the PUF settles after each challenge change before sampling; legal range 1..255.
REQ-002 Parameter NUM_CHAL, default 64: challenges per run; must be a multiple of 8, range 8..256.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  run request, sampled only in IDLE.
REQ-006 seed  in  8  first challenge of the run.
REQ-007 cnt_reset  out  1  drives the up_counter synchronous reset (loads cnt_start).
REQ-008 cnt_enable  out  1  drives the up_counter enable (advance one challenge).
REQ-009 cnt_start  out  8  seed latched at run start, drives the up_counter start value.
REQ-010 challenge  in  8  current up_counter output.
REQ-011 puf_resp  in  1  PUF response bit for the current challenge.
REQ-012 resp_data  out  8  eight packed responses; bit i = response to the i-th challenge of the word.
REQ-013 resp_tag  out  8  challenge value of bit 0 of resp_data.
REQ-014 resp_valid  out  1  / resp_ready  in  1  valid/ready output handshake.
REQ-015 busy  out  1  high in every state except IDLE; done  out  1  one-cycle end-of-run pulse.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, SETTLE, SAMPLE, STEP, EMIT, FINISH.
REQ-017 IDLE: start=1 SHALL latch seed into cnt_start, clear challenge and bit counters, and go to LOAD; start while busy SHALL be ignored.
REQ-018 LOAD: cnt_reset=1 for exactly one cycle; next state SETTLE.
REQ-019 SETTLE: stays exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-020 SAMPLE: one cycle; SHALL write puf_resp to resp_data[bit_idx]; at bit_idx=0 SHALL capture challenge into resp_tag; increments challenge count; bit_idx=7 goes to EMIT, otherwise STEP.
REQ-021 STEP: cnt_enable=1 for exactly one cycle; next state SETTLE.
REQ-022 EMIT: resp_valid=1; resp_data and resp_tag SHALL be stable until resp_valid&&resp_ready; on handshake go to FINISH if challenge count = NUM_CHAL, else STEP.
REQ-023 FINISH: done=1 for one cycle; next state IDLE; the counter SHALL NOT be advanced after the last sample.
REQ-024 cnt_reset and cnt_enable SHALL never be high together, and SHALL be low outside LOAD and STEP respectively.
REQ-025 Per-challenge period SHALL be SETTLE_CYCLES+2 cycles; resp_valid SHALL rise 8*(SETTLE_CYCLES+2) rising edges after the edge that samples start (back-pressure-free).
REQ-026 Challenge wrap 0xFF->0x00 SHALL be transparent: tags follow the counter modulo 256.
REQ-027 Challenge count SHALL be 9 bits so NUM_CHAL=256 terminates correctly.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE and all outputs to 0 (cnt_start, resp_data, resp_tag included), from any state, including mid-SETTLE or mid-EMIT.
REQ-029 A word held in EMIT at reset SHALL be discarded; the next start SHALL restart from the new seed.

Structure
REQ-030 Shared package puf_pkg SHALL hold the state enum, CHAL_W=8 and RESP_W=8 constants.
REQ-031 Single module; the settle timer is an internal down-counter, and up_counter is instantiated beside it at the parent level, not inside.

Verification (SETTLE_CYCLES=2, NUM_CHAL=16, bench models up_counter, puf_resp=challenge[0])
REQ-032 seed=0x10, resp_ready=1 -> words {data 0xAA, tag 0x10}, {0xAA, 0x18}; first resp_valid 32 edges after start; done one cycle after the second handshake.
REQ-033 seed=0xFC -> tags 0xFC then 0x04, data 0xAA both words.
REQ-034 puf_resp tied 1 and resp_ready low 10 cycles in EMIT -> resp_data=0xFF held stable, no cnt_enable or sample during the stall.
REQ-035 start pulsed while busy -> ignored, cnt_start unchanged; reset low during SETTLE -> all outputs 0 next cycle, busy=0; new start with seed=0x40 -> tag 0x40.
REQ-036 Every cycle, assert !(cnt_reset&&cnt_enable) and exactly 16 cnt_enable pulses minus 1 per run.
